// File: rtl/wasm_operand_stack.sv
// WebAssembly operand stack: pop up to two and push one entry per cycle.
// Optional entry type checking on pops: define WASM_OPERAND_STACK_TYPECHECK_EN.
module wasm_operand_stack #(
  parameter int DEPTH = 16,
  parameter bit USE_64B = 1'b1,
  localparam int DW = USE_64B ? 64 : 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    pop_cnt,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [1:0]    push_type,
  input  logic          trap_clr,
`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
  input  logic [1:0]    expect_type,
  input  logic [1:0]    check,
`endif
  output logic [DW-1:0] top0,
  output logic [1:0]    top0_type,
  output logic [DW-1:0] top1,
  output logic [1:0]    top1_type,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic [3:0]    trap
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F64 = 2'd3;
  localparam logic [DW-1:0] LO_MASK = DW'(32'hFFFF_FFFF);

  logic [DW-1:0] mem_data [DEPTH];
  logic [1:0]    mem_type [DEPTH];

  logic [CW-1:0] cnt;
  logic [3:0]    trap_q;
  logic [DW-1:0] t0_q, t1_q;
  logic [1:0]    ty0_q, ty1_q;

  logic [CW:0]   cnt_x, pop_x, base_x, n_x;
  logic          wide, underflow, illegal, overflow, mismatch;
  logic          active, commit;
  logic [3:0]    err;
  logic [DW-1:0] wdata;
  logic [DW-1:0] t0_n, t1_n;
  logic [1:0]    ty0_n, ty1_n;

  assign cnt_x  = {1'b0, cnt};
  assign pop_x  = (CW+1)'(pop_cnt);
  assign base_x = cnt_x - pop_x;
  assign n_x    = base_x + (CW+1)'(push);

  assign wide      = (push_type == T_I64) || (push_type == T_F64);
  assign underflow = (pop_cnt == 2'd3) || (pop_x > cnt_x);
  assign illegal   = push && !USE_64B && wide;
  assign overflow  = n_x > (CW+1)'(DEPTH);

`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
  // popped entry 0/1 are exactly the registered top0/top1
  assign mismatch =
    (check[0] && (pop_cnt != 2'd0) && (ty0_q != expect_type)) ||
    (check[1] && (pop_cnt >= 2'd2) && (ty1_q != expect_type));
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    err = 4'd0;
    priority case (1'b1)
      underflow: err = 4'd2;
      mismatch:  err = 4'd4;
      illegal:   err = 4'd3;
      overflow:  err = 4'd1;
      default:   err = 4'd0;
    endcase
  end

  assign active = !trap_clr && (trap_q == 4'd0) && !flush;
  assign commit = active && (err == 4'd0);

  // narrow types never carry stale upper bits
  assign wdata = wide ? push_data : (push_data & LO_MASK);

  always_comb begin
    t0_n  = '0;
    ty0_n = '0;
    t1_n  = '0;
    ty1_n = '0;
    if (push) begin
      t0_n  = wdata;
      ty0_n = push_type;
    end else if (n_x >= (CW+1)'(1)) begin
      t0_n  = mem_data[AW'(n_x - (CW+1)'(1))];
      ty0_n = mem_type[AW'(n_x - (CW+1)'(1))];
    end
    if (n_x >= (CW+1)'(2)) begin
      t1_n  = mem_data[AW'(n_x - (CW+1)'(2))];
      ty1_n = mem_type[AW'(n_x - (CW+1)'(2))];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && commit && push) begin
      mem_data[AW'(base_x)] <= wdata;
      mem_type[AW'(base_x)] <= push_type;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      trap_q <= '0;
      t0_q   <= '0;
      ty0_q  <= '0;
      t1_q   <= '0;
      ty1_q  <= '0;
    end else if (trap_clr) begin
      trap_q <= '0;
    end else if (trap_q == 4'd0) begin
      if (flush) begin
        cnt   <= '0;
        t0_q  <= '0;
        ty0_q <= '0;
        t1_q  <= '0;
        ty1_q <= '0;
      end else if (err != 4'd0) begin
        trap_q <= err;
      end else begin
        cnt   <= CW'(n_x);
        t0_q  <= t0_n;
        ty0_q <= ty0_n;
        t1_q  <= t1_n;
        ty1_q <= ty1_n;
      end
    end
  end

  assign top0      = t0_q;
  assign top0_type = ty0_q;
  assign top1      = t1_q;
  assign top1_type = ty1_q;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign trap      = trap_q;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed bench for wasm_operand_stack with a reference stack model
// and a queue of expected observations.
module tb_wasm_operand_stack;

  localparam logic [1:0] I32 = 2'd0;
  localparam logic [1:0] I64 = 2'd1;
  localparam logic [1:0] F32 = 2'd2;
  localparam logic [1:0] F64 = 2'd3;
`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  pop_cnt = 2'd0;
  logic        push = 1'b0;
  logic [63:0] push_data = '0;
  logic [1:0]  push_type = I32;
  logic        trap_clr = 1'b0;
  logic [1:0]  expect_t = I32;
  logic [1:0]  check_v = 2'b00;

  logic [63:0] top0, top1;
  logic [1:0]  top0_type, top1_type;
  logic [2:0]  count;
  logic        empty, full;
  logic [3:0]  trap;

  logic        n_push = 1'b0;
  logic [31:0] n_data = '0;
  logic [1:0]  n_type = I32;
  logic [31:0] n_top0, n_top1;
  logic [1:0]  n_ty0, n_ty1;
  logic [2:0]  n_count;
  logic        n_empty, n_full;
  logic [3:0]  n_trap;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [63:0] t0;
    logic [1:0]  ty0;
    logic [63:0] t1;
    logic [1:0]  ty1;
    logic        emp;
    logic        ful;
    logic [3:0]  trp;
  } obs_t;

  obs_t        exp_q[$];
  logic [63:0] md[$];
  logic [1:0]  mt[$];
  logic [3:0]  mtrap = 4'd0;

  wasm_operand_stack #(.DEPTH(4), .USE_64B(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .pop_cnt(pop_cnt),
    .push(push), .push_data(push_data), .push_type(push_type),
    .trap_clr(trap_clr),
`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
    .expect_type(expect_t), .check(check_v),
`endif
    .top0(top0), .top0_type(top0_type), .top1(top1),
    .top1_type(top1_type), .count(count), .empty(empty),
    .full(full), .trap(trap)
  );

  wasm_operand_stack #(.DEPTH(4), .USE_64B(1'b0)) u_n32 (
    .clk(clk), .reset(reset), .flush(1'b0), .pop_cnt(2'd0),
    .push(n_push), .push_data(n_data), .push_type(n_type),
    .trap_clr(1'b0),
`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
    .expect_type(2'd0), .check(2'b00),
`endif
    .top0(n_top0), .top0_type(n_ty0), .top1(n_top1),
    .top1_type(n_ty1), .count(n_count), .empty(n_empty),
    .full(n_full), .trap(n_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic f, input logic [1:0] p,
                       input logic ps, input logic [63:0] d,
                       input logic [1:0] t, input logic tc,
                       input logic [1:0] ck, input logic [1:0] et);
    int c;
    obs_t o;
    logic [3:0] e;
    logic [63:0] w;
    c = md.size();
    if (tc) mtrap = 4'd0;
    else if (mtrap == 4'd0) begin
      if (f) begin
        md.delete();
        mt.delete();
      end else begin
        e = 4'd0;
        if (p == 2'd3 || int'(p) > c) e = 4'd2;
        else if (TC && ((ck[0] && p >= 1 && mt[c-1] != et) ||
                        (ck[1] && p >= 2 && mt[c-2] != et))) e = 4'd4;
        else if (c - int'(p) + int'(ps) > 4) e = 4'd1;
        if (e != 4'd0) mtrap = e;
        else begin
          repeat (int'(p)) begin
            void'(md.pop_back());
            void'(mt.pop_back());
          end
          if (ps) begin
            w = d;
            if (t == I32 || t == F32) w[63:32] = '0;
            md.push_back(w);
            mt.push_back(t);
          end
        end
      end
    end
    c = md.size();
    o.cnt = 3'(c);
    o.t0  = (c >= 1) ? md[c-1] : 64'd0;
    o.ty0 = (c >= 1) ? mt[c-1] : 2'd0;
    o.t1  = (c >= 2) ? md[c-2] : 64'd0;
    o.ty1 = (c >= 2) ? mt[c-2] : 2'd0;
    o.emp = (c == 0);
    o.ful = (c == 4);
    o.trp = mtrap;
    exp_q.push_back(o);
  endtask

  task automatic compare(input string tag);
    obs_t o;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 64'd0, 64'd1);
      return;
    end
    o = exp_q.pop_front();
    chk({tag, ".count"}, 64'(count), 64'(o.cnt));
    chk({tag, ".top0"}, top0, o.t0);
    chk({tag, ".top0_type"}, 64'(top0_type), 64'(o.ty0));
    chk({tag, ".top1"}, top1, o.t1);
    chk({tag, ".top1_type"}, 64'(top1_type), 64'(o.ty1));
    chk({tag, ".empty"}, 64'(empty), 64'(o.emp));
    chk({tag, ".full"}, 64'(full), 64'(o.ful));
    chk({tag, ".trap"}, 64'(trap), 64'(o.trp));
  endtask

  task automatic step(input string tag, input logic f, input logic [1:0] p,
                      input logic ps, input logic [63:0] d,
                      input logic [1:0] t, input logic tc,
                      input logic [1:0] ck = 2'b00,
                      input logic [1:0] et = 2'd0);
    flush = f; pop_cnt = p; push = ps; push_data = d;
    push_type = t; trap_clr = tc; check_v = ck; expect_t = et;
    model(f, p, ps, d, t, tc, ck, et);
    @(posedge clk);
    #1;
    compare(tag);
    flush = 0; pop_cnt = 0; push = 0; trap_clr = 0; check_v = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".count"}, 64'(count), 64'd0);
    chk({tag, ".top0"}, top0, 64'd0);
    chk({tag, ".top1"}, top1, 64'd0);
    chk({tag, ".types"}, 64'({top0_type, top1_type}), 64'd0);
    chk({tag, ".empty"}, 64'(empty), 64'd1);
    chk({tag, ".full"}, 64'(full), 64'd0);
    chk({tag, ".trap"}, 64'(trap), 64'd0);
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    step("add_push1", 0, 2'd0, 1, 64'd1, I32, 0);
    step("add_push2", 0, 2'd0, 1, 64'd2, I32, 0);
    step("add_pop2push", 0, 2'd2, 1, 64'd3, I32, 0);
    step("pop_last", 0, 2'd1, 0, 64'd0, I32, 0);

    for (int i = 0; i < 5; i++)
      step($sformatf("fill%0d", i), 0, 2'd0, 1,
           64'hA5A5_0000_0000_0010 + 64'(i), I64, 0);
    step("ovf_ignored", 0, 2'd0, 1, 64'hDEAD, I64, 0);
    step("ovf_clr", 0, 2'd0, 1, 64'hBEEF, I64, 1);
    step("full_pop1push", 0, 2'd1, 1, 64'h55, I32, 0);
    step("full_pop2push", 0, 2'd2, 1, 64'h66, F32, 0);

    step("flush_full", 1, 2'd0, 0, 64'd0, I32, 0);
    step("udf_empty", 0, 2'd1, 1, 64'h77, I32, 0);
    step("udf_clr", 0, 2'd0, 0, 64'd0, I32, 1);
    step("one_push", 0, 2'd0, 1, 64'h99, F32, 0);
    step("udf_pop2", 0, 2'd2, 0, 64'd0, I32, 0);
    step("udf2_clr", 0, 2'd0, 0, 64'd0, I32, 1);
    step("pop3", 0, 2'd3, 0, 64'd0, I32, 0);
    step("pop3_clr", 0, 2'd0, 0, 64'd0, I32, 1);
    step("pop_one", 0, 2'd1, 0, 64'd0, I32, 0);
    step("mask_i32", 0, 2'd0, 1, 64'hFFFF_FFFF_0000_0007, I32, 0);
    step("keep_f64", 0, 2'd0, 1, 64'hFFFF_FFFF_0000_0008, F64, 0);
    step("push3", 0, 2'd0, 1, 64'hC, I64, 0);
    step("flush_push", 1, 2'd0, 1, 64'hD, I32, 0);

`ifdef WASM_OPERAND_STACK_TYPECHECK_EN
    step("tc_push_i32", 0, 2'd0, 1, 64'h1, I32, 0);
    step("tc_push_f32", 0, 2'd0, 1, 64'h2, F32, 0);
    step("tc_mismatch", 0, 2'd2, 0, 64'd0, I32, 0, 2'b11, I32);
    step("tc_clr", 0, 2'd0, 0, 64'd0, I32, 1);
    step("tc_match", 0, 2'd1, 0, 64'd0, I32, 0, 2'b01, F32);
    step("tc_flush", 1, 2'd0, 0, 64'd0, I32, 0);
`endif

    n_push = 1; n_data = 32'h7; n_type = I32;
    @(posedge clk);
    #1;
    n_push = 1; n_data = 32'h8; n_type = F64;
    chk("n32_push.count", 64'(n_count), 64'd1);
    chk("n32_push.top0", 64'(n_top0), 64'h7);
    @(posedge clk);
    #1;
    n_push = 0;
    chk("n32_illegal.trap", 64'(n_trap), 64'd3);
    chk("n32_illegal.count", 64'(n_count), 64'd1);
    chk("n32_illegal.top0", 64'(n_top0), 64'h7);

    step("burst1", 0, 2'd0, 1, 64'h11, I32, 0);
    step("burst2", 0, 2'd0, 1, 64'h12, I64, 0);
    step("burst3", 0, 2'd0, 1, 64'h13, F32, 0);
    push = 1; push_data = 64'h14; push_type = I32;
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    md.delete();
    mt.delete();
    mtrap = 4'd0;
    @(posedge clk);
    #1;
    push = 0;
    chk_zero("rst_hold");
    reset = 1'b1;
    step("after_rst", 0, 2'd0, 0, 64'd0, I32, 0);
    step("after_rst_push", 0, 2'd0, 1, 64'h21, F32, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wasm_operand_stack.md
Name: wasm_operand_stack

Overview:
- Parametrised WebAssembly operand stack for the core.
- Holds typed values and sources the core's result/result_type/result_empty outputs.
- Each cycle it can pop up to two entries and push one, so a binary op such as i32.add (pop 2, push 1) commits in a single cycle.
- Generalises the fixed single-width stack: configurable depth and data width, 64-bit type gating, flush, and sticky trap reporting.

Parameters:
- DEPTH, 16, number of entries (≥2).
- USE_64B, 1, 1: entries are 64 bits and i64/f64 are legal; 0: entries are 32 bits and i64/f64 pushes trap.
- DW, (USE_64B ? 64 : 32), derived entry width; not overridable.
- CW, $clog2(DEPTH+1), width of the count output.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  empty the stack (frame exit).
- pop_cnt  input  2  entries to pop this cycle, 0..2; value 3 is illegal.
- push  input  1  push push_data/push_type this cycle.
- push_data  input  DW  value to push.
- push_type  input  2  type code from core.svh: i32, i64, f32, f64.
- trap_clr  input  1  clear the sticky trap.
- top0  output  DW  top-of-stack value.
- top0_type  output  2  top-of-stack type.
- top1  output  DW  second entry value.
- top1_type  output  2  second entry type.
- count  output  CW  current number of entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- trap  output  4  0 = none, 1 = overflow, 2 = underflow, 3 = illegal type, 4 = type mismatch (optional feature only).

Behaviour:
- Reset (asynchronous, reset low):
  - count=0, empty=1, full=0, trap=0.
  - top0=top1=0, top0_type=top1_type=0.
  - Storage contents are don't-care.
- Operation per rising edge, in priority order:
  1. trap_clr: trap<=0. All other inputs are ignored that cycle.
  2. trap!=0 (sticky): ignore flush, pop_cnt and push; state is frozen.
  3. flush: count<=0. pop_cnt and push are ignored that cycle.
  4. Otherwise, with n = count − pop_cnt + push:
     - pop_cnt > count: trap<=2, no state change.
     - pop_cnt==3: trap<=2, no state change.
     - push with USE_64B=0 and push_type ∈ {i64, f64}: trap<=3, no state change.
     - n > DEPTH: trap<=1, no state change.
     - Otherwise: remove pop_cnt entries, then write the pushed entry at index count−pop_cnt, and set count<=n.
  - When several error conditions hold in the same cycle, the check order is underflow, then illegal type, then overflow.
- Width rule: when push_type is i32 or f32 and DW=64, bits [63:32] are written as 0 regardless of push_data.
- Top outputs:
  - Registered; they reflect state after the last edge, with zero combinational path from inputs.
  - top0 = entry[count−1] and top1 = entry[count−2].
  - A missing entry reads as value 0, type 0.
- Latency:
  - A push is visible on top0 the cycle after the edge.
  - Back-to-back operations every cycle are supported with no bubbles.
  - Pop 2 / push 1 leaves count−1 entries with top0 = the pushed value.
- Boundaries:
  - Push at full with pop_cnt≥1 is legal (net count unchanged or decreasing).
  - Pop 2 from count==2 with push gives count=1.
  - Pop from empty with push and pop_cnt=1: underflow trap, push discarded.
  - Reset asserted mid-operation aborts immediately; no partial write survives.
- full, empty and count are always consistent with each other.

Optional Feature:
- Macro: WASM_OPERAND_STACK_TYPECHECK_EN.
- When defined:
  - Adds input expect_type[1:0] and input check[1:0].
  - On a non-trapping cycle with check[i]=1 and pop_cnt>i, the type of popped entry i (0 = top) must equal expect_type.
  - On mismatch: trap<=4 and no state change. The check is evaluated after underflow and before illegal type.
- When undefined:
  - The ports are absent.
  - Trap code 4 is never produced.
  - No type comparison logic is generated.

Test Plan:
- Reset low, then high; push i32 1, then push i32 2, then pop_cnt=2 with push i32 3 → count=1, top0=3, top0_type=i32, empty=0, trap=0 (models i32.add).
- DEPTH=4: five consecutive pushes of i64 → after the 4th push full=1, count=4; 5th push gives trap=1 with count and top0 unchanged; further pushes are ignored; trap_clr → trap=0; pop_cnt=1 with push of 0x55 → count=4, top0=0x55.
- pop_cnt=1 on an empty stack → trap=2, count=0. Same cycle with pop_cnt=2 and count=1 → trap=2, entry preserved.
- USE_64B=0: push f64 → trap=3. With USE_64B=1, push i32 with push_data 0xFFFF_FFFF_0000_0007 → top0=0x0000_0000_0000_0007.
- Three pushes then flush asserted together with push → count=0, empty=1, top0=0. Assert reset low mid-burst → all outputs 0 asynchronously, before the next edge.
- WASM_OPERAND_STACK_TYPECHECK_EN: stack holds i32, f32; pop_cnt=2 with check=2'b11 and expect_type=i32 → trap=4, count=2.
